// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the mips32 unified-memory port.
//   arb_state_t : arbiter FSM states
//   REQ_IF/REQ_DM : requester ids
//   MIPS_ADDR_W/MIPS_DATA_W : default widths shared with the core
package mips32_mem_pkg;

    localparam int unsigned MIPS_ADDR_W = 10;
    localparam int unsigned MIPS_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (IF)
// and the data stage (DM). Data wins by default; a starvation counter forces
// a fetch grant after STARVE_MAX consecutive data grants. All outputs are
// registered.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   halted                      masks fetch requests
//   if_req/if_addr              fetch request; if_gnt/if_rvalid/if_rdata back
//   dm_req/dm_we/dm_addr/dm_wdata  data request; dm_gnt/dm_rvalid/dm_rdata back
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side
//   busy                        FSM not in IDLE
module mem_port_arbiter
    import mips32_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = MIPS_ADDR_W,
    parameter int unsigned DATA_W     = MIPS_DATA_W,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halted,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int unsigned LAT_W = 3;
    localparam int unsigned SC_W  = (STARVE_MAX < 4) ? 2 : $clog2(STARVE_MAX + 1);

    arb_state_t        state, state_nxt;
    logic [LAT_W-1:0]  lat_cnt, lat_nxt;
    logic [SC_W-1:0]   starve_cnt, starve_nxt;
    logic              owner, owner_nxt;
    logic              is_wr, is_wr_nxt;

    logic              if_gnt_nxt, dm_gnt_nxt;
    logic              if_rvalid_nxt, dm_rvalid_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;
    logic              mem_en_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              busy_nxt;

    logic              if_eff;
    logic              dm_win;

    assign if_eff = if_req & ~halted;
    assign dm_win = dm_req & (~if_eff | (starve_cnt < SC_W'(STARVE_MAX)));

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        lat_nxt       = lat_cnt;
        starve_nxt    = starve_cnt;
        owner_nxt     = owner;
        is_wr_nxt     = is_wr;
        if_gnt_nxt    = 1'b0;
        dm_gnt_nxt    = 1'b0;
        if_rvalid_nxt = 1'b0;
        dm_rvalid_nxt = 1'b0;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;

        case (state)
            IDLE: begin
                if (dm_win) begin
                    owner_nxt     = REQ_DM;
                    is_wr_nxt     = dm_we;
                    dm_gnt_nxt    = 1'b1;
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    state_nxt     = ISSUE;
                    // Count data grants that make a pending fetch wait
                    if (if_eff) begin
                        starve_nxt = (starve_cnt == SC_W'(STARVE_MAX)) ?
                                     starve_cnt : starve_cnt + SC_W'(1);
                    end else begin
                        starve_nxt = '0;
                    end
                end else if (if_eff) begin
                    owner_nxt    = REQ_IF;
                    is_wr_nxt    = 1'b0;
                    if_gnt_nxt   = 1'b1;
                    mem_en_nxt   = 1'b1;
                    mem_addr_nxt = if_addr;
                    starve_nxt   = '0;
                    state_nxt    = ISSUE;
                end else begin
                    starve_nxt = '0;
                end
            end
            ISSUE: begin
                if (is_wr) begin
                    state_nxt = IDLE;
                end else begin
                    lat_nxt   = LAT_W'(MEM_LAT);
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                lat_nxt = lat_cnt - LAT_W'(1);
                // Last WAIT cycle is the one with valid mem_rdata
                if (lat_cnt <= LAT_W'(1)) begin
                    if (owner == REQ_DM) begin
                        dm_rvalid_nxt = 1'b1;
                        dm_rdata_nxt  = mem_rdata;
                    end else begin
                        if_rvalid_nxt = 1'b1;
                        if_rdata_nxt  = mem_rdata;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (halted) begin
            starve_nxt = '0;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner      <= REQ_IF;
            is_wr      <= 1'b0;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            lat_cnt    <= lat_nxt;
            starve_cnt <= starve_nxt;
            owner      <= owner_nxt;
            is_wr      <= is_wr_nxt;
            if_gnt     <= if_gnt_nxt;
            dm_gnt     <= dm_gnt_nxt;
            if_rvalid  <= if_rvalid_nxt;
            dm_rvalid  <= dm_rvalid_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with its own behavioural memory.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: MEM_LAT = 1
    logic        halted, if_req, dm_req, dm_we;
    logic [9:0]  if_addr, dm_addr;
    logic [31:0] dm_wdata;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    // Instance B: MEM_LAT = 3
    logic        b_halted, b_if_req, b_dm_req, b_dm_we;
    logic [9:0]  b_if_addr, b_dm_addr;
    logic [31:0] b_dm_wdata;
    logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
    logic [9:0]  b_mem_addr;

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) dut_a (
        .clk(clk), .rst(rst), .halted(halted),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(3)) dut_b (
        .clk(clk), .rst(rst), .halted(b_halted),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    // Memory A: synchronous read, data valid one cycle after mem_en
    logic [31:0] mem_a [1024];
    logic [31:0] pipe_a;
    always @(posedge clk) begin
        if (rst) begin
            mem_a[10'h010] <= 32'hDEAD_BEEF;
            mem_a[10'h030] <= 32'hCAFE_F00D;
        end else if (mem_en) begin
            if (mem_we) mem_a[mem_addr] <= mem_wdata;
            else        pipe_a <= mem_a[mem_addr];
        end
    end
    assign mem_rdata = pipe_a;

    // Memory B: synchronous read plus two pipeline stages (three cycles)
    logic [31:0] mem_b [1024];
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        if (rst) begin
            mem_b[10'h005] <= 32'h0BAD_C0DE;
            mem_b[10'h007] <= 32'h7777_0007;
        end else if (b_mem_en && b_mem_we) begin
            mem_b[b_mem_addr] <= b_mem_wdata;
        end
        pipe_b[0] <= mem_b[b_mem_addr];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign b_mem_rdata = pipe_b[2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         ng, ig, dv, rv, nb, bg, rvc;
    logic       gseq [8];
    logic [7:0] exp_pat;

    initial begin
        rst = 1'b1;
        halted = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        b_halted = 1'b0; b_if_req = 1'b0; b_if_addr = '0;
        b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_dm_gnt", 32'(dm_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_b_busy", 32'(b_busy), 0);

        // Single fetch read, MEM_LAT=1
        if_req = 1'b1; if_addr = 10'h010;
        tick();
        chk("f_if_gnt", 32'(if_gnt), 1);
        chk("f_mem_en", 32'(mem_en), 1);
        chk("f_mem_we", 32'(mem_we), 0);
        chk("f_mem_addr", 32'(mem_addr), 32'h010);
        if_req = 1'b0;
        tick();
        chk("f_busy_wait", 32'(busy), 1);
        chk("f_rvalid_early", 32'(if_rvalid), 0);
        tick();
        chk("f_if_rvalid", 32'(if_rvalid), 1);
        chk("f_if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("f_dm_rdata_hold", dm_rdata, 0);
        chk("f_busy_idle", 32'(busy), 0);
        tick();
        chk("f_rvalid_pulse", 32'(if_rvalid), 0);
        chk("f_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // Simultaneous store and fetch: store first, fetch two cycles later
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h020; dm_wdata = 32'h1234_5678;
        if_req = 1'b1; if_addr = 10'h030;
        tick();
        chk("s_dm_gnt", 32'(dm_gnt), 1);
        chk("s_if_gnt", 32'(if_gnt), 0);
        chk("s_mem_we", 32'(mem_we), 1);
        chk("s_mem_addr", 32'(mem_addr), 32'h020);
        chk("s_mem_wdata", mem_wdata, 32'h1234_5678);
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
        chk("s_gap_gnt", 32'(if_gnt | dm_gnt), 0);
        chk("s_mem_written", mem_a[10'h020], 32'h1234_5678);
        tick();
        chk("s_if_gnt_late", 32'(if_gnt), 1);
        chk("s_if_mem_we", 32'(mem_we), 0);
        if_req = 1'b0;
        tick(); tick();
        chk("s_if_rvalid", 32'(if_rvalid), 1);
        chk("s_if_rdata", if_rdata, 32'hCAFE_F00D);

        // Starvation bound with both requesters held, data loads
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h020;
        if_req = 1'b1; if_addr = 10'h010;
        ng = 0;
        for (int c = 0; c < 60 && ng < 8; c++) begin
            tick();
            if (if_gnt && dm_gnt) chk("st_double_gnt", 1, 0);
            if (if_gnt) begin gseq[ng] = 1'b1; ng++; end
            else if (dm_gnt) begin gseq[ng] = 1'b0; ng++; end
        end
        dm_req = 1'b0; if_req = 1'b0;
        chk("st_grant_count", 32'(ng), 8);
        exp_pat = 8'b1000_1000;
        for (int i = 0; i < ng && i < 8; i++) begin
            chk($sformatf("st_grant_%0d", i), 32'(gseq[i]), 32'(exp_pat[i]));
        end
        for (int c = 0; c < 10 && busy; c++) tick();
        chk("st_drain", 32'(busy), 0);
        tick();

        // Reset during WAIT of a fetch read
        if_req = 1'b1; if_addr = 10'h010;
        tick();
        chk("r_if_gnt", 32'(if_gnt), 1);
        if_req = 1'b0;
        tick();
        chk("r_in_wait", 32'(busy), 1);
        rst = 1'b1;
        tick();
        chk("r_busy", 32'(busy), 0);
        chk("r_if_rvalid", 32'(if_rvalid), 0);
        chk("r_if_rdata", if_rdata, 0);
        chk("r_mem_en", 32'(mem_en), 0);
        chk("r_mem_addr", 32'(mem_addr), 0);
        rst = 1'b0;
        rv = 0;
        repeat (4) begin
            tick();
            if (if_rvalid) rv++;
        end
        chk("r_no_rvalid", 32'(rv), 0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
        tick();
        chk("r_dm_gnt", 32'(dm_gnt), 1);
        dm_req = 1'b0;
        tick(); tick();
        chk("r_dm_rvalid", 32'(dm_rvalid), 1);
        chk("r_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        tick();

        // Halted: fetch masked, data load still served
        halted = 1'b1; if_req = 1'b1; if_addr = 10'h030;
        ig = 0; dv = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h030; end
            tick();
            if (if_gnt) ig++;
            if (dm_gnt) dm_req = 1'b0;
            if (dm_rvalid) begin
                dv++;
                chk("h_dm_rdata", dm_rdata, 32'hCAFE_F00D);
            end
        end
        chk("h_no_if_gnt", 32'(ig), 0);
        chk("h_dm_done", 32'(dv), 1);
        halted = 1'b0;
        tick();
        chk("h_if_gnt_after", 32'(if_gnt), 1);
        if_req = 1'b0;
        tick(); tick();
        chk("h_if_rvalid", 32'(if_rvalid), 1);
        chk("h_if_rdata", if_rdata, 32'hCAFE_F00D);

        // MEM_LAT=3 data load with a fetch waiting
        b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 10'h005;
        b_if_req = 1'b1; b_if_addr = 10'h007;
        tick();
        chk("l3_dm_gnt", 32'(b_dm_gnt), 1);
        chk("l3_if_gnt", 32'(b_if_gnt), 0);
        b_dm_req = 1'b0;
        nb = b_busy ? 1 : 0;
        bg = 0; rvc = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (b_busy) nb++;
            if (b_if_gnt || b_dm_gnt) bg++;
            if (b_dm_rvalid) rvc = c;
        end
        chk("l3_busy_cycles", 32'(nb), 4);
        chk("l3_no_gnt_wait", 32'(bg), 0);
        chk("l3_rvalid_cycle", 32'(rvc), 5);
        chk("l3_dm_rdata", b_dm_rdata, 32'h0BAD_C0DE);
        tick();
        chk("l3_if_gnt_next", 32'(b_if_gnt), 1);
        b_if_req = 1'b0;
        repeat (4) tick();
        chk("l3_if_rvalid", 32'(b_if_rvalid), 1);
        chk("l3_if_rdata", b_if_rdata, 32'h7777_0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
